// File: rtl/aes_key_pkg.sv
// Shared constants, key-length codes and read-FSM encoding for the AES round-key store.
package aes_key_pkg;

  localparam int KEY_W    = 128;
  localparam int NUM_KEYS = 15;
  localparam int IDX_W    = 4;
  localparam logic [IDX_W-1:0] MAX_IDX = 4'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    KL_NONE = 2'b00,
    KL_128  = 2'b01,
    KL_192  = 2'b10,
    KL_256  = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } rd_state_e;

  // Index of the final round key for a key length; meaningless for KL_NONE.
  function automatic logic [IDX_W-1:0] last_round(input logic [1:0] len);
    case (len)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic in_range(input logic [1:0] len, input logic [IDX_W-1:0] idx);
    return (len != KL_NONE) && (idx <= last_round(len));
  endfunction

  function automatic logic [NUM_KEYS-1:0] sched_mask(input logic [1:0] len);
    logic [NUM_KEYS-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (in_range(len, IDX_W'(i))) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/round_key_ram.sv
// Round-key array: one synchronous write port, one combinational read port.
module round_key_ram
  import aes_key_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [KEY_W-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [KEY_W-1:0] o_rdata
);

  logic [KEY_W-1:0] r_mem [NUM_KEYS];

  // NOTE: the array has no reset; entry validity is tracked separately, so stale data is never served.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = (i_raddr <= MAX_IDX) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/round_key_mem.sv
// Round-key store: captures expanded subkeys, tracks per-entry validity, and serves
// keys to the cipher through a request/response handshake that stalls on missing keys.
module round_key_mem
  import aes_key_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] waddr,
  input  logic [KEY_W-1:0] subkey,
  input  logic             clear_valid,
  input  logic [1:0]       key_len,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_addr,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_err,
  output logic             all_ready
);

  rd_state_e        r_state, w_state_next;
  logic [IDX_W-1:0] r_req_addr, w_req_addr_next;
  logic [KEY_W-1:0] r_rd_key, w_key_next;
  logic             r_rd_err, w_err_next;
  logic [NUM_KEYS-1:0] r_vbit, w_vbit_next, w_mask;
  logic             r_all_ready;
  logic             w_wr_ok;
  logic [IDX_W-1:0] w_raddr;
  logic [KEY_W-1:0] w_rdata;
  logic             w_vbit_hit;

  assign w_wr_ok = wr_en && (waddr <= MAX_IDX);
  assign w_mask  = sched_mask(key_len);

  round_key_ram u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (waddr),
    .i_wdata (subkey),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Clear first, then the write, so a colliding write leaves exactly its own entry valid.
  always_comb begin
    w_vbit_next = clear_valid ? '0 : r_vbit;
    if (w_wr_ok) w_vbit_next[waddr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking (<=); combinational blocks use blocking (=).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vbit      <= '0;
      r_all_ready <= 1'b0;
    end else begin
      r_vbit      <= w_vbit_next;
      r_all_ready <= (key_len != KL_NONE) && ((w_vbit_next & w_mask) == w_mask);
    end
  end

  // In IDLE the incoming address is looked up directly so a hit responds next cycle.
  assign w_raddr    = (r_state == ST_IDLE) ? rd_addr : r_req_addr;
  assign w_vbit_hit = (w_raddr <= MAX_IDX) && r_vbit[w_raddr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_req_addr <= '0;
      r_rd_key   <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_req_addr <= w_req_addr_next;
      r_rd_key   <= w_key_next;
      r_rd_err   <= w_err_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    w_state_next    = r_state;
    w_req_addr_next = r_req_addr;
    w_key_next      = r_rd_key;
    w_err_next      = r_rd_err;
    case (r_state)
      ST_IDLE: begin
        if (rd_req) begin
          w_req_addr_next = rd_addr;
          if (!in_range(key_len, rd_addr)) begin
            w_state_next = ST_RESP;
            w_key_next   = '0;
            w_err_next   = 1'b1;
          end else if (w_vbit_hit) begin
            w_state_next = ST_RESP;
            w_key_next   = w_rdata;
            w_err_next   = 1'b0;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_vbit_hit) begin
          w_state_next = ST_RESP;
          w_key_next   = w_rdata;
          w_err_next   = 1'b0;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rd_ready  = (r_state == ST_IDLE);
  assign rd_valid  = (r_state == ST_RESP);
  assign rd_key    = r_rd_key;
  assign rd_err    = r_rd_err;
  assign all_ready = r_all_ready;

endmodule
